// File: rtl/tile_lane_engine.sv
// tile_lane_engine: scrolls a LANES x DEPTH tile field fed by a pattern source and
// judges active-low button presses against the hit row (score, combo, lives, game over).
module tile_lane_engine #(
    parameter int LANES    = 3,
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 50000000,
    parameter int SCORE_W  = 10,
    parameter int LIVES    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LANES-1:0]         btn,
    input  logic [LANES-1:0]         pat_data,
    input  logic                     pat_valid,
    output logic                     pat_ready,
    output logic [DEPTH*LANES-1:0]   field,
    output logic                     step,
    output logic [SCORE_W-1:0]       score,
    output logic [SCORE_W-1:0]       combo,
    output logic [3:0]               lives,
    output logic                     game_over
);
    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [LANES-1:0] btn_q, flag, hit_row, press, hit_v, flag_n, miss_v;
    logic run, go, wrong, penalty;
    logic [3:0] hits, misses, loss;
    logic [SCORE_W+3:0] s_sum, c_sum;

    function automatic logic [3:0] pop(input logic [LANES-1:0] v);
        pop = '0;
        for (int i = 0; i < LANES; i++) pop = pop + {3'b0, v[i]};
    endfunction

    // A RUN cycle with lives already at zero only hands over to OVER; nothing else happens.
    assign go        = start && state != RUN;
    assign run       = state == RUN && lives != 4'd0;
    assign pat_ready = run && cnt == CW'(TICK_DIV - 1);
    assign game_over = state == OVER;

    assign hit_row = field[(DEPTH-1)*LANES +: LANES];
    assign press   = btn_q & ~btn;
    assign hit_v   = press & hit_row & ~flag;
    assign wrong   = |(press & ~hit_row);
    assign flag_n  = flag | hit_v;
    assign miss_v  = pat_ready ? hit_row & ~flag_n : '0;
    assign hits    = pop(hit_v);
    assign misses  = pop(miss_v);
    assign loss    = misses > lives ? lives : misses;
    assign penalty = wrong || misses != 4'd0;
    assign s_sum   = {4'b0, score} + {{SCORE_W{1'b0}}, hits};
    assign c_sum   = {4'b0, combo} + {{SCORE_W{1'b0}}, hits};

    always_comb begin
        state_n = state;
        if (go)
            state_n = RUN;
        else if (state == RUN && lives == 4'd0)
            state_n = OVER;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= '1;
            cnt   <= '0;
            field <= '0;
            flag  <= '0;
            step  <= 1'b0;
            score <= '0;
            combo <= '0;
            lives <= 4'(LIVES);
        end else begin
            btn_q <= btn;
            // Registered one cycle early so step lines up with pat_ready.
            step  <= run && cnt == CW'(TICK_DIV - 2);
            if (go) begin
                cnt   <= '0;
                field <= '0;
                flag  <= '0;
                score <= '0;
                combo <= '0;
                lives <= 4'(LIVES);
            end else if (run) begin
                cnt   <= pat_ready ? '0 : cnt + 1'b1;
                flag  <= pat_ready ? '0 : flag_n;
                score <= |s_sum[SCORE_W+3:SCORE_W] ? '1 : s_sum[SCORE_W-1:0];
                combo <= penalty ? '0 : |c_sum[SCORE_W+3:SCORE_W] ? '1 : c_sum[SCORE_W-1:0];
                lives <= lives - loss;
                if (pat_ready)
                    field <= {field[(DEPTH-1)*LANES-1:0], pat_valid ? pat_data : {LANES{1'b0}}};
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_tile_lane_engine.sv
// tb_tile_lane_engine: scenario tasks plus randomized traffic, checked against an
// array-based game model that replays the rules one clock at a time.
module tb_tile_lane_engine;
    localparam int L = 3, D = 4, TD = 4, SW = 4, LV = 3;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, pat_valid = 1'b0;
    logic [L-1:0] btn = '1, pat_data = '0;
    logic pat_ready, step, game_over;
    logic [D*L-1:0] field;
    logic [SW-1:0] score, combo;
    logic [3:0] lives;

    tile_lane_engine #(.LANES(L), .DEPTH(D), .TICK_DIV(TD), .SCORE_W(SW), .LIVES(LV)) dut (
        .clk(clk), .rst(rst), .start(start), .btn(btn), .pat_data(pat_data),
        .pat_valid(pat_valid), .pat_ready(pat_ready), .field(field), .step(step),
        .score(score), .combo(combo), .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    // model: 0 idle, 1 run, 2 over
    int mstate = 0, mcnt = 0, mscore = 0, mcombo = 0, mlives = LV;
    logic [L-1:0] mrow [D];
    logic [L-1:0] mflag = '0, mprev = '1;
    logic m_step = 1'b0, obs_step, obs_ready;

    function automatic logic [D*L-1:0] mfield();
        logic [D*L-1:0] f;
        for (int r = 0; r < D; r++) f[r*L +: L] = mrow[r];
        return f;
    endfunction

    task automatic model_clear();
        mcnt = 0; mscore = 0; mcombo = 0; mlives = LV; mflag = '0;
        for (int r = 0; r < D; r++) mrow[r] = '0;
    endtask

    task automatic model_edge();
        int hits = 0, misses = 0;
        bit wrong = 0, act;
        logic [L-1:0] h;
        act = mstate == 1 && mlives > 0;
        m_step = act && mcnt == TD - 1;
        h = mrow[D-1];
        if (rst) begin
            mstate = 0; model_clear();
        end else if (start && mstate != 1) begin
            mstate = 1; model_clear();
        end else if (act) begin
            for (int i = 0; i < L; i++)
                if (mprev[i] && !btn[i]) begin
                    if (!h[i]) wrong = 1;
                    else if (!mflag[i]) begin hits++; mflag[i] = 1'b1; end
                end
            if (m_step) begin
                for (int i = 0; i < L; i++) if (h[i] && !mflag[i]) misses++;
                for (int r = D - 1; r > 0; r--) mrow[r] = mrow[r-1];
                mrow[0] = pat_valid ? pat_data : '0;
                mflag = '0;
            end
            mscore = (mscore + hits > SMAX) ? SMAX : mscore + hits;
            mcombo = (wrong || misses > 0) ? 0 : (mcombo + hits > SMAX) ? SMAX : mcombo + hits;
            mlives = mlives - ((misses < mlives) ? misses : mlives);
            mcnt = (mcnt + 1) % TD;
        end else begin
            if (mstate == 1) mstate = 2;
            mcnt = 0;
        end
        mprev = rst ? '1 : btn;
    endtask

    // One clock: sample combinational/pre-edge outputs, advance model, land on negedge.
    task automatic clk1();
        #1;
        obs_step = step;
        obs_ready = pat_ready;
        model_edge();
        @(negedge clk);
    endtask

    // Push one row in at the next step and run until it sits in the hit row.
    task automatic feed_row(input logic [L-1:0] p, input bit keep);
        int n = 0, guard = 0;
        pat_valid = 1'b1; pat_data = p;
        while (n < D && guard < 4 * TD * D) begin
            clk1(); guard++;
            if (obs_step) begin n++; if (!keep) pat_valid = 1'b0; end
        end
        checks++; if (n != D) begin failures++; $display("FAIL feed_steps got=%0d exp=%0d", n, D); end
    endtask

    task automatic test_reset();
        rst = 1'b1; clk1(); clk1(); rst = 1'b0;
        checks++; if (field !== '0) begin failures++; $display("FAIL reset_field got=%h exp=0", field); end
        checks++; if (score !== '0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score); end
        checks++; if (combo !== '0) begin failures++; $display("FAIL reset_combo got=%0d exp=0", combo); end
        checks++; if (lives !== 4'd3) begin failures++; $display("FAIL reset_lives got=%0d exp=3", lives); end
        checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL reset_over got=%b exp=0", game_over); end
        checks++; if (step !== 1'b0 || pat_ready !== 1'b0) begin failures++; $display("FAIL reset_step got=%b%b exp=00", step, pat_ready); end
    endtask

    task automatic test_scroll();
        int n = 0;
        start = 1'b1; clk1(); start = 1'b0;
        pat_valid = 1'b1; pat_data = 3'b101;
        for (int c = 0; c < 4 * TD; c++) begin
            clk1();
            checks++; if (obs_step !== m_step) begin failures++; $display("FAIL scroll_step c=%0d got=%b exp=%b", c, obs_step, m_step); end
            checks++; if (obs_ready !== m_step) begin failures++; $display("FAIL scroll_ready c=%0d got=%b exp=%b", c, obs_ready, m_step); end
            if (obs_step) begin
                n++; pat_valid = 1'b0;
                if (n == 1) begin
                    checks++; if (field[2:0] !== 3'b101) begin failures++; $display("FAIL scroll_row0 got=%b exp=101", field[2:0]); end
                end
            end
        end
        checks++; if (n != 4) begin failures++; $display("FAIL scroll_count got=%0d exp=4", n); end
        checks++; if (field[11:9] !== 3'b101) begin failures++; $display("FAIL scroll_hitrow got=%b exp=101", field[11:9]); end
        checks++; if (field !== mfield()) begin failures++; $display("FAIL scroll_field got=%h exp=%h", field, mfield()); end
    endtask

    task automatic test_hit();
        btn = 3'b010; clk1(); btn = '1;
        checks++; if (score !== 4'd2 || combo !== 4'd2) begin failures++; $display("FAIL hit_pair got=%0d/%0d exp=2/2", score, combo); end
        clk1(); btn = 3'b110; clk1(); btn = '1;
        checks++; if (score !== 4'd2 || combo !== 4'd2) begin failures++; $display("FAIL hit_repeat got=%0d/%0d exp=2/2", score, combo); end
        clk1();
        checks++; if (lives !== 4'd3) begin failures++; $display("FAIL hit_lives got=%0d exp=3", lives); end
        checks++; if (field !== mfield()) begin failures++; $display("FAIL hit_field got=%h exp=%h", field, mfield()); end
    endtask

    task automatic test_wrong();
        feed_row(3'b001, 1'b0);
        btn = 3'b101; clk1(); btn = '1;
        checks++; if (combo !== 4'd0 || score !== 4'd2) begin failures++; $display("FAIL wrong_press got=%0d/%0d exp=0/2", combo, score); end
        checks++; if (lives !== 4'd3) begin failures++; $display("FAIL wrong_lives got=%0d exp=3", lives); end
        clk1(); clk1(); clk1();
        checks++; if (lives !== 4'd2) begin failures++; $display("FAIL miss_lives got=%0d exp=2", lives); end
    endtask

    task automatic test_game_over();
        feed_row(3'b111, 1'b0);
        clk1(); clk1(); clk1(); clk1();
        checks++; if (lives !== 4'd0 || game_over !== 1'b0) begin failures++; $display("FAIL over_lives got=%0d/%b exp=0/0", lives, game_over); end
        start = 1'b1; clk1();
        checks++; if (game_over !== 1'b1) begin failures++; $display("FAIL over_enter got=%b exp=1", game_over); end
        checks++; if (obs_ready !== 1'b0) begin failures++; $display("FAIL over_ready got=%b exp=0", obs_ready); end
        clk1(); start = 1'b0;
        checks++; if (obs_ready !== 1'b0) begin failures++; $display("FAIL over_ready2 got=%b exp=0", obs_ready); end
        checks++; if (game_over !== 1'b0 || lives !== 4'd3) begin failures++; $display("FAIL restart got=%b/%0d exp=0/3", game_over, lives); end
        checks++; if (score !== '0 || combo !== '0 || field !== '0) begin failures++; $display("FAIL restart_clear got=%0d/%0d/%h exp=0/0/0", score, combo, field); end
    endtask

    task automatic test_saturate();
        feed_row(3'b111, 1'b1);
        for (int k = 0; k < 6; k++) begin
            btn = 3'b000; clk1(); btn = '1; clk1(); clk1(); clk1();
            checks++; if (score !== mscore[SW-1:0]) begin failures++; $display("FAIL sat_score k=%0d got=%0d exp=%0d", k, score, mscore); end
        end
        pat_valid = 1'b0;
        checks++; if (score !== 4'd15 || combo !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d/%0d exp=15/15", score, combo); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = $urandom_range(0, 199) == 0;
            start = $urandom_range(0, 15) == 0;
            btn = L'($urandom); pat_valid = 1'($urandom); pat_data = L'($urandom);
            clk1();
            checks++; if (obs_step !== m_step || obs_ready !== m_step) begin failures++; $display("FAIL rand_step c=%0d got=%b%b exp=%b", c, obs_step, obs_ready, m_step); end
            checks++; if (field !== mfield()) begin failures++; $display("FAIL rand_field c=%0d got=%h exp=%h", c, field, mfield()); end
            checks++; if (score !== mscore[SW-1:0] || combo !== mcombo[SW-1:0]) begin failures++; $display("FAIL rand_score c=%0d got=%0d/%0d exp=%0d/%0d", c, score, combo, mscore, mcombo); end
            checks++; if (lives !== mlives[3:0]) begin failures++; $display("FAIL rand_lives c=%0d got=%0d exp=%0d", c, lives, mlives); end
            checks++; if (game_over !== (mstate == 2)) begin failures++; $display("FAIL rand_over c=%0d got=%b exp=%b", c, game_over, mstate == 2); end
        end
        rst = 1'b0; start = 1'b0; btn = '1; pat_valid = 1'b0;
    endtask

    task automatic test_rst_mid();
        int s = 0;
        rst = 1'b1; clk1(); rst = 1'b0;
        start = 1'b1; clk1(); start = 1'b0;
        feed_row(3'b111, 1'b0);
        clk1(); clk1(); clk1();
        btn = 3'b000; start = 1'b1; rst = 1'b1; clk1();
        checks++; if (obs_step !== 1'b1) begin failures++; $display("FAIL rstmid_step got=%b exp=1", obs_step); end
        checks++; if (field !== '0 || score !== '0 || combo !== '0) begin failures++; $display("FAIL rstmid_clear got=%h/%0d/%0d exp=0/0/0", field, score, combo); end
        checks++; if (lives !== 4'd3 || game_over !== 1'b0 || step !== 1'b0 || pat_ready !== 1'b0) begin failures++; $display("FAIL rstmid_out got=%0d/%b/%b/%b exp=3/0/0/0", lives, game_over, step, pat_ready); end
        rst = 1'b0; start = 1'b0; btn = '1;
        for (int c = 0; c < 2 * TD; c++) begin clk1(); s += obs_step; end
        checks++; if (s != 0) begin failures++; $display("FAIL rstmid_idle steps=%0d exp=0", s); end
    endtask

    initial begin
        for (int r = 0; r < D; r++) mrow[r] = '0;
        test_reset();
        test_scroll();
        test_hit();
        test_wrong();
        test_game_over();
        test_saturate();
        test_random();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tile_lane_engine.md
# tile_lane_engine

Parametrised successor to the fixed 3-lane tile game core. Scrolls a LANES-wide, DEPTH-row tile field one row per TICK_DIV clocks and pulls new rows from an upstream pattern source through a valid/ready handshake. Judges active-low button presses against the hit row: per-tile hit flags, wrong-press and missed-tile detection, combo, lives and a game-over state. Feeds the seven-segment score path and the dot/VGA field renderers.

## Interface
- LANES, 3: number of lanes/buttons (1..8)
- DEPTH, 16: rows in the visible field; row DEPTH-1 is the hit row
- TICK_DIV, 50000000: clocks per scroll step (>=2)
- SCORE_W, 10: score and combo width
- LIVES, 3: misses allowed before game over (1..15)

- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- start  in  1  level; begins a game from IDLE or OVER
- btn  in  LANES  buttons, active-low, already debounced and synchronised
- pat_data  in  LANES  next row from pattern source, bit i = tile in lane i
- pat_valid  in  1  pat_data holds a row
- pat_ready  out  1  engine consumes pat_data this cycle
- field  out  DEPTH*LANES  row r at [r*LANES +: LANES]; row 0 = newest
- step  out  1  one-cycle pulse on each scroll
- score  out  SCORE_W  tiles hit, saturating
- combo  out  SCORE_W  consecutive hits, saturating
- lives  out  4  remaining lives
- game_over  out  1  high in OVER

## Operation
- States: IDLE -> RUN on start; RUN -> OVER when lives reaches 0; OVER -> RUN on start. IDLE/OVER: tick counter held at 0, field frozen, no judging, pat_ready=0.
- Entering RUN (from IDLE or OVER): field, hit flags, score, combo cleared; lives=LIVES; tick counter=0.
- Tick counter: 0..TICK_DIV-1 in RUN; step asserted in the cycle the counter equals TICK_DIV-1, counter wraps to 0.
- On step: row r+1 <= row r; row 0 <= pat_data if pat_valid else all zero (gap row). pat_ready = step in RUN; transfer = pat_valid & pat_ready. Upstream never stalls the engine.
- Hit flags (LANES bits) belong to the current hit row; cleared on every step.
- Press = falling edge of btn[i] (previous sample 1, current 0); btn history register reset to all ones.
- Per pressed lane i, judged against current hit row H: H[i]=1 and flag[i]=0 -> hit, set flag[i]; H[i]=1 and flag[i]=1 -> ignored; H[i]=0 -> wrong press.
- Missed tile: on step, each lane with H[i]=1 and flag[i]=0 (after including presses in that same cycle) counts one miss.
- Per-cycle update: score += hits; combo += hits if no wrong press and no miss this cycle, else combo <= 0 (hits in that cycle discarded from combo). lives -= min(misses, lives). Score and combo saturate at 2^SCORE_W-1.
- lives reaching 0 moves to OVER in the following cycle; score/combo/field hold in OVER.

## Timing
- Reset values: state IDLE, pat_ready 0, field 0, step 0, score 0, combo 0, lives LIVES, game_over 0.
- All outputs registered except pat_ready (decoded from counter and state, same cycle as step).
- Press to score/combo update: 1 cycle after the btn sample that shows the falling edge.
- Press in a step cycle judges the pre-shift hit row; flags clear after.
- rst mid-game wins over every other event, including start, step and press.
- start held in RUN has no effect; start in the cycle lives hits 0 is ignored (OVER entered first).

## Test plan
- LANES=3, DEPTH=4, TICK_DIV=4: start, feed 3'b101 then zeros -> step every 4 clocks, row appears at field[2:0] after first step, reaches hit row [11:9] after 4th step; pat_ready pulses match step.
- Tile 3'b101 in hit row, press lanes 0 and 2 -> score 2, combo 2, lives 3; repeat press lane 0 -> no change.
- Tile 3'b001 in hit row, press lane 1 -> wrong press, combo 0, score unchanged; tile then scrolls out unhit -> lives 2.
- Row 3'b111 unhit at step with lives=2 -> lives 0, game_over next cycle, pat_ready stays 0; start -> RUN, score 0, lives 3.
- SCORE_W=4: 16 hits -> score and combo hold at 15.
- Assert rst during RUN with step and press in same cycle -> all outputs at reset values next cycle, state IDLE.
